// File: rtl/note2dds_mv_gen_pkg.sv
// note2dds_pkg: shared constants, semitone increment table and FSM state
// encoding for the note-to-DDS phase-increment generator.
package note2dds_pkg;

  localparam int NOTE_W  = 7;
  localparam int SEMIS   = 12;
  localparam int OCT_TOP = 10;
  localparam int TBL_W   = 21;

  // Increments for octave 10; entry 12 is twice entry 0 and only serves as
  // the upper interpolation point for semitone 11.
  localparam logic [TBL_W-1:0] NOTE2DDS_TBL [13] = '{
    21'd359575, 21'd380957, 21'd403610, 21'd427610, 21'd453037,
    21'd479976, 21'd508516, 21'd538754, 21'd570790, 21'd604731,
    21'd640691, 21'd678788, 21'd719150
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIV    = 3'd1,
    ST_LOOK   = 3'd2,
    ST_INTERP = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_WRITE  = 3'd5
  } n2d_state_e;

  // Table read with out-of-range indices mapped to zero.
  function automatic logic [TBL_W-1:0] tbl_lookup(input logic [3:0] idx);
    logic [TBL_W-1:0] val;
    if (idx <= 4'd12) begin
      val = NOTE2DDS_TBL[idx];
    end else begin
      val = '0;
    end
    return val;
  endfunction

endpackage

// File: rtl/note2dds_mv_gen_if.sv
// note2dds_mv_gen_if: request handshake, update strobe and flat increment bus.
// master = voice allocator side, slave = generator side.
interface note2dds_mv_gen_if #(
  parameter int VOICES = 4,
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 7
);
  localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

  logic                    req_valid;
  logic                    req_ready;
  logic [VW-1:0]           req_voice;
  logic [6:0]              req_note;
  logic [FRAC_W-1:0]       req_bend;
  logic                    upd_valid;
  logic [VW-1:0]           upd_voice;
  logic [VOICES*OUT_W-1:0] adder;

  modport master (
    output req_valid, req_voice, req_note, req_bend,
    input  req_ready, upd_valid, upd_voice, adder
  );

  modport slave (
    input  req_valid, req_voice, req_note, req_bend,
    output req_ready, upd_valid, upd_voice, adder
  );
endinterface

// File: rtl/note2dds_mv_gen_div12.sv
// note2dds_div12: sequential divide-by-12 by repeated subtraction.
// o_done is high for one cycle once the remainder drops below 12, i.e.
// oct+1 cycles after i_start; o_oct/o_rem hold until the next start.
module note2dds_div12
  import note2dds_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [NOTE_W-1:0] i_note,
  output logic              o_done,
  output logic [3:0]        o_oct,
  output logic [3:0]        o_rem
);

  logic              r_busy;
  logic [NOTE_W-1:0] r_rem;
  logic [3:0]        r_oct;

  // Load on start, then subtract one octave per cycle until rem < 12.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_rem  <= '0;
      r_oct  <= 4'd0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_rem  <= i_note;
      r_oct  <= 4'd0;
    end else if (r_busy) begin
      if (r_rem >= NOTE_W'(SEMIS)) begin
        r_rem <= r_rem - NOTE_W'(SEMIS);
        r_oct <= r_oct + 4'd1;
      end else begin
        r_busy <= 1'b0;
      end
    end else begin
      r_busy <= 1'b0;
    end
  end

  assign o_done = r_busy && (r_rem < NOTE_W'(SEMIS));
  assign o_oct  = r_oct;
  assign o_rem  = r_rem[3:0];

endmodule

// File: rtl/note2dds_mv_gen.sv
// note2dds_mv_gen: multi-voice note-to-DDS phase-increment generator.
// Optional feature macro NOTE2DDS_BEND_EN enables fractional pitch-bend
// interpolation; without it INTERP passes the table value through.
module note2dds_mv_gen
  import note2dds_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 7
) (
  input logic               clk,
  input logic               rst_n,
  note2dds_mv_gen_if.slave  bus
);

  localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [VW:0] VOICES_L = (VW+1)'(VOICES);

  n2d_state_e r_state, w_next_state;
  logic       w_accept;
  logic       w_div_done;
  logic [3:0] w_oct, w_rem, w_shamt;
  logic       w_voice_ok;

  logic [VW-1:0]                r_voice;
  logic [TBL_W-1:0]             r_base;
  logic [TBL_W-1:0]             r_val;
  logic [TBL_W-1:0]             w_interp;
  logic [VOICES-1:0][OUT_W-1:0] r_adder;
  logic                         r_upd_valid;
  logic [VW-1:0]                r_upd_voice;

`ifdef NOTE2DDS_BEND_EN
  localparam int PROD_W = TBL_W + FRAC_W;
  logic [FRAC_W-1:0] r_bend;
  logic [TBL_W-1:0]  r_next;
  logic [PROD_W-1:0] w_prod;
  // Table entries rise monotonically, so the difference is never negative.
  assign w_prod   = PROD_W'(r_next - r_base) * PROD_W'(r_bend);
  assign w_interp = r_base + w_prod[PROD_W-1:FRAC_W];
`else
  logic w_unused_bend;
  assign w_unused_bend = ^bus.req_bend;
  assign w_interp      = r_base;
`endif

  note2dds_div12 u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept),
    .i_note  (bus.req_note),
    .o_done  (w_div_done),
    .o_oct   (w_oct),
    .o_rem   (w_rem)
  );

  assign w_shamt    = 4'(OCT_TOP) - w_oct;
  assign w_voice_ok = ({1'b0, r_voice} < VOICES_L);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state and handshake acceptance.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_DIV;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (w_div_done) begin
          w_next_state = ST_LOOK;
        end else begin
          w_next_state = ST_DIV;
        end
      end
      ST_LOOK:   w_next_state = ST_INTERP;
      ST_INTERP: w_next_state = ST_SHIFT;
      ST_SHIFT:  w_next_state = ST_WRITE;
      ST_WRITE:  w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: latch request, look up, interpolate, scale by octave, commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_voice     <= '0;
      r_base      <= '0;
      r_val       <= '0;
      r_adder     <= '0;
      r_upd_valid <= 1'b0;
      r_upd_voice <= '0;
`ifdef NOTE2DDS_BEND_EN
      r_bend      <= '0;
      r_next      <= '0;
`endif
    end else begin
      r_upd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_voice <= bus.req_voice;
`ifdef NOTE2DDS_BEND_EN
            r_bend  <= bus.req_bend;
`endif
          end
        end
        ST_LOOK: begin
          r_base <= tbl_lookup(w_rem);
`ifdef NOTE2DDS_BEND_EN
          r_next <= tbl_lookup(w_rem + 4'd1);
`endif
        end
        ST_INTERP: r_val <= w_interp;
        ST_SHIFT:  r_val <= r_val >> w_shamt;
        ST_WRITE: begin
          if (w_voice_ok) begin
            for (int v = 0; v < VOICES; v++) begin
              if (r_voice == VW'(v)) begin
                r_adder[v] <= OUT_W'(r_val);
              end
            end
            r_upd_valid <= 1'b1;
            r_upd_voice <= r_voice;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.upd_valid = r_upd_valid;
  assign bus.upd_voice = r_upd_voice;
  assign bus.adder     = r_adder;

endmodule

// File: tb/tb_note2dds_mv_gen.sv
// Self-checking bench for note2dds_mv_gen: behavioural per-cycle model,
// directed literal cases, back-to-back, overwrite, mid-op reset, random.
module tb_note2dds_mv_gen;

  localparam int VOICES = 4;
  localparam int OUT_W  = 32;
  localparam int FRAC_W = 7;

`ifdef NOTE2DDS_BEND_EN
  localparam bit BEND_EN     = 1'b1;
  localparam int EXP_60_64   = 11570;
  localparam int EXP_11_127  = 701;
`else
  localparam bit BEND_EN     = 1'b0;
  localparam int EXP_60_64   = 11236;
  localparam int EXP_11_127  = 662;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  note2dds_mv_gen_if #(.VOICES(VOICES), .OUT_W(OUT_W), .FRAC_W(FRAC_W)) bus ();

  note2dds_mv_gen #(.VOICES(VOICES), .OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int tbl [13] = '{359575, 380957, 403610, 427610, 453037, 479976, 508516,
                   538754, 570790, 604731, 640691, 678788, 719150};

  // Reference: octave/semitone by integer division, optional bend, octave scale.
  function automatic longint model_val(int note, int bend);
    int oct, rem;
    longint v;
    oct = note / 12;
    rem = note % 12;
    v   = tbl[rem];
    if (BEND_EN) v = v + ((longint'(tbl[rem+1] - tbl[rem]) * bend) / (1 << FRAC_W));
    return v / (longint'(1) << (10 - oct));
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle model and compare ----------------
  int     cyc = 0;
  bit     pend = 1'b0;
  int     pend_due, pend_voice;
  longint pend_val;
  longint exp_adder [VOICES];
  bit     exp_upd;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend = 1'b0;
      for (int v = 0; v < VOICES; v++) exp_adder[v] = 0;
      check("rst_upd_valid", bus.upd_valid, 0);
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_adder_zero", (bus.adder == '0), 1);
    end else begin
      exp_upd = pend && (pend_due == cyc);
      if (exp_upd) begin
        exp_adder[pend_voice] = pend_val;
        pend = 1'b0;
      end
      check("upd_valid", bus.upd_valid, exp_upd);
      check("req_ready", bus.req_ready, !pend);
      if (exp_upd) check("upd_voice", bus.upd_voice, pend_voice);
      for (int v = 0; v < VOICES; v++)
        check($sformatf("adder[%0d]", v), longint'(bus.adder[v*OUT_W +: OUT_W]), exp_adder[v]);
      if (bus.req_valid && !pend) begin
        pend       = 1'b1;
        pend_voice = int'(bus.req_voice);
        pend_val   = model_val(int'(bus.req_note), int'(bus.req_bend));
        pend_due   = cyc + int'(bus.req_note) / 12 + 6;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_accept(input string name);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      t++;
      if (t > 40) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_accept: req_ready still 0 after %0d cycles, expected 1", name, t);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_upd(input string name, input int note, input int voice, input longint exp_val);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.upd_valid && lat < 40);
    check({name, "_latency"}, lat, note / 12 + 5);
    if (exp_val >= 0) check({name, "_value"}, longint'(bus.adder[voice*OUT_W +: OUT_W]), exp_val);
  endtask

  task automatic do_req(input int voice, input int note, input int bend, input longint exp_val, input string name);
    bus.req_valid = 1'b1;
    bus.req_voice = 2'(voice);
    bus.req_note  = 7'(note);
    bus.req_bend  = 7'(bend);
    wait_accept(name);
    bus.req_valid = 1'b0;
    bus.req_voice = 2'($urandom_range(0, 3));
    bus.req_note  = 7'($urandom_range(0, 127));
    bus.req_bend  = 7'($urandom_range(0, 127));
    wait_upd(name, note, voice, exp_val);
  endtask

  // ---------------- stimulus ----------------
  int pulses;
  initial begin
    bus.req_valid = 1'b0;
    bus.req_voice = '0;
    bus.req_note  = '0;
    bus.req_bend  = '0;

    check("pin_n69", model_val(69, 0), 18897);
    check("pin_n0", model_val(0, 0), 351);
    check("pin_n127", model_val(127, 0), 538754);
    check("pin_n60b64", model_val(60, 64), EXP_60_64);
    check("pin_n11b127", model_val(11, 127), EXP_11_127);
    check("pin_n50", model_val(50, 0), 6306);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1, 69, 0, 18897, "n69_v1");
    do_req(0, 0, 0, 351, "n0_v0");
    do_req(2, 127, 0, 538754, "n127_v2");
    do_req(0, 60, 64, EXP_60_64, "n60b64_v0");
    do_req(1, 11, 127, EXP_11_127, "n11b127_v1");

    // Overwrite the same voice.
    do_req(3, 48, 0, 5618, "n48_v3");
    do_req(3, 50, 0, 6306, "n50_v3");

    // Back-to-back: second request held valid through the first update.
    bus.req_valid = 1'b1;
    bus.req_voice = 2'd0;
    bus.req_note  = 7'd60;
    bus.req_bend  = 7'd0;
    wait_accept("b2b_first");
    bus.req_voice = 2'd2;
    bus.req_note  = 7'd72;
    wait_upd("b2b_first", 60, 0, 11236);
    check("b2b_ready_on_upd", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_upd("b2b_second", 72, 2, 22473);

    // Reset during the DIV phase of a note-120 request.
    bus.req_valid = 1'b1;
    bus.req_voice = 2'd2;
    bus.req_note  = 7'd120;
    wait_accept("midrst");
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("midrst_adder_zero", (bus.adder == '0), 1);
    check("midrst_ready", bus.req_ready, 1);
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.upd_valid) pulses++;
    end
    check("midrst_no_upd", pulses, 0);

    // Randomised traffic against the per-cycle model.
    for (int i = 0; i < 40; i++) begin
      do_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 127)),
             int'($urandom_range(0, 127)), -1, "rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
